ula_acumulador: RTL

// - Accumulator ALU stage. Sits directly downstream of the mux+register stage: its 4-bit registered output drives dado_in.
// - Combines each accepted operand with an internal accumulator (load/add/sub/logic/clear), and sets status flags.
// - Also performs an iterative shift-add multiply that stalls the input handshake until it completes.
// - Its result feeds the next datapath stage and the status/branch logic.

---
 rtl/ula_acumulador_pkg.sv | 22 ++
 rtl/ula_acumulador_if.sv | 28 ++
 rtl/ula_acumulador_mult.sv | 50 +++++
 rtl/ula_acumulador.sv | 125 ++++++++++++
 4 files changed

// File: rtl/ula_acumulador_pkg.sv
// Shared types for the accumulator ALU: operation codes and FSM states.
package ula_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_LOAD = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_AND  = 3'b011,
    OP_OR   = 3'b100,
    OP_XOR  = 3'b101,
    OP_MUL  = 3'b110,
    OP_CLR  = 3'b111
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/ula_acumulador_if.sv
// Operand handshake and result/status bus of the accumulator ALU stage.
interface ula_acumulador_if #(
  parameter int unsigned W = 4
);
  import ula_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] op;
  logic [W-1:0]    dado_in;
  logic [W-1:0]    acc_out;
  logic            flag_zero;
  logic            flag_carry;
  logic            flag_overflow;
  logic            out_valid;
  logic            busy;

  modport master (
    output in_valid, op, dado_in,
    input  in_ready, acc_out, flag_zero, flag_carry, flag_overflow, out_valid, busy
  );

  modport slave (
    input  in_valid, op, dado_in,
    output in_ready, acc_out, flag_zero, flag_carry, flag_overflow, out_valid, busy
  );

endinterface

// File: rtl/ula_acumulador_mult.sv
// Serial shift-add multiplier: operands latch on start, one partial product per edge.
module multiplicador_serial #(
  parameter int unsigned W     = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] produto
);

  logic [2*W-1:0] mcand;
  logic [2*W-1:0] acc_p;
  logic [2*W-1:0] partial;
  logic [W-1:0]   mplier;
  logic [CNT_W-1:0] cnt;
  logic           run;

  // produto already includes the current step, so the final value is
  // available combinationally during the cycle that ends with the W-th edge.
  assign partial = mplier[0] ? mcand : '0;
  assign produto = acc_p + partial;
  assign done    = run && (cnt == CNT_W'(W-1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      run    <= 1'b0;
      cnt    <= '0;
      acc_p  <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      run    <= 1'b1;
      cnt    <= '0;
      acc_p  <= '0;
      mcand  <= {{W{1'b0}}, a};
      mplier <= b;
    end else if (run) begin
      acc_p  <= produto;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/ula_acumulador.sv
// Accumulator ALU stage: single-cycle load/arith/logic ops plus a stalling serial multiply.
module ula_acumulador #(
  parameter int unsigned W     = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  ula_acumulador_if.slave bus
);
  import ula_pkg::*;

  state_e         state, state_nxt;
  logic [W-1:0]   acc, acc_nxt;
  logic           zero_q, zero_nxt;
  logic           carry_q, carry_nxt;
  logic           ovf_q, ovf_nxt;
  logic           valid_q, valid_nxt;
  logic           fire;
  logic           mul_start;
  logic           mul_done;
  logic [2*W-1:0] produto;
  logic [W:0]     sum;
  logic [W:0]     diff;
  op_e            op;

  assign op       = op_e'(bus.op);
  assign fire     = bus.in_valid && bus.in_ready;
  assign sum      = {1'b0, acc} + {1'b0, bus.dado_in};
  assign diff     = {1'b0, acc} - {1'b0, bus.dado_in};

  assign bus.in_ready      = (state == ST_IDLE);
  assign bus.busy          = (state == ST_MUL);
  assign bus.acc_out       = acc;
  assign bus.flag_zero     = zero_q;
  assign bus.flag_carry    = carry_q;
  assign bus.flag_overflow = ovf_q;
  assign bus.out_valid     = valid_q;

  multiplicador_serial #(
    .W     (W),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (acc),
    .b       (bus.dado_in),
    .done    (mul_done),
    .produto (produto)
  );

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    zero_nxt  = zero_q;
    carry_nxt = carry_q;
    ovf_nxt   = ovf_q;
    valid_nxt = 1'b0;
    mul_start = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (fire) begin
          if (op == OP_MUL) begin
            mul_start = 1'b1;
            state_nxt = ST_MUL;
          end else begin
            valid_nxt = 1'b1;
            carry_nxt = 1'b0;
            ovf_nxt   = 1'b0;
            unique case (op)
              OP_LOAD: acc_nxt = bus.dado_in;
              OP_ADD: begin
                acc_nxt   = sum[W-1:0];
                carry_nxt = sum[W];
                ovf_nxt   = (acc[W-1] == bus.dado_in[W-1]) && (sum[W-1] != acc[W-1]);
              end
              OP_SUB: begin
                acc_nxt   = diff[W-1:0];
                carry_nxt = diff[W];
                ovf_nxt   = (acc[W-1] != bus.dado_in[W-1]) && (diff[W-1] != acc[W-1]);
              end
              OP_AND:  acc_nxt = acc & bus.dado_in;
              OP_OR:   acc_nxt = acc | bus.dado_in;
              OP_XOR:  acc_nxt = acc ^ bus.dado_in;
              OP_CLR:  acc_nxt = '0;
              default: acc_nxt = acc;
            endcase
            zero_nxt = (acc_nxt == '0);
          end
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          acc_nxt   = produto[W-1:0];
          carry_nxt = |produto[2*W-1:W];
          ovf_nxt   = 1'b0;
          zero_nxt  = (produto[W-1:0] == '0);
          valid_nxt = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      acc     <= '0;
      zero_q  <= 1'b1;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      acc     <= acc_nxt;
      zero_q  <= zero_nxt;
      carry_q <= carry_nxt;
      ovf_q   <= ovf_nxt;
      valid_q <= valid_nxt;
    end
  end

endmodule
